// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: reset fill, load-use stall,
// branch flush and memory freeze. Optional perf counters: PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int RST_HOLD    = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {START, RUN, MEM_WAIT} state_t;

  localparam int          WAIT_W    = $clog2(MEM_TIMEOUT + 2);
  localparam logic [3:0]  HOLD_LAST = 4'(RST_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic        WD_ON     = (MEM_TIMEOUT != 0);

  state_t            state, state_n;
  logic [3:0]        hold_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              lu_done;
  logic              hazard, lu_stall, advance;

  logic run_pc, run_if_id_en, run_id_ex_en, run_ex_mem_en, run_mem_wb_en;
  logic run_if_id_flush, run_id_ex_flush, run_br, run_lu;

  assign hazard = ex_is_load & ex_reg_wr & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  // The bubble moves the load on, so a hazard still visible right after its
  // bubble is the same hazard and must not stall a second time.
  assign lu_stall = hazard & ~lu_done;
  assign wait_inc = wait_cnt + WAIT_W'(1);

  // Advancing-cycle rules shared by RUN and the MEM_WAIT release cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    run_pc          = 1'b1;
    run_if_id_en    = 1'b1;
    run_id_ex_en    = 1'b1;
    run_ex_mem_en   = 1'b1;
    run_mem_wb_en   = 1'b1;
    run_if_id_flush = 1'b0;
    run_id_ex_flush = 1'b0;
    run_br          = 1'b0;
    run_lu          = 1'b0;
    if (ex_br_taken) begin
      run_if_id_flush = 1'b1;
      run_id_ex_flush = 1'b1;
      run_br          = 1'b1;
    end else if (lu_stall) begin
      run_pc          = 1'b0;
      run_if_id_en    = 1'b0;
      run_id_ex_flush = 1'b1;
      run_lu          = 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    advance     = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (state)
      START: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (hold_cnt == HOLD_LAST) state_n = RUN;
      end
      RUN: begin
        if (mem_req && !mem_ready) state_n = MEM_WAIT;
        else                       advance = 1'b1;
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          advance = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = START;
    endcase
    if (advance) begin
      pc_en       = run_pc;
      if_id_en    = run_if_id_en;
      id_ex_en    = run_id_ex_en;
      ex_mem_en   = run_ex_mem_en;
      mem_wb_en   = run_mem_wb_en;
      if_id_flush = run_if_id_flush;
      id_ex_flush = run_id_ex_flush;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state       <= START;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      lu_done     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == START) hold_cnt <= hold_cnt + 4'd1;
      if (advance) lu_done <= run_lu;
      if (state == MEM_WAIT && !mem_ready) begin
        if (WD_ON && wait_cnt != WAIT_MAX) wait_cnt <= wait_inc;
        if (WD_ON && wait_inc == WAIT_MAX) err_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state != START && !pc_en) stall_q <= stall_q + CNT_W'(1);
      if (advance && run_br)        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (RST_HOLD=2, MEM_TIMEOUT=4),
// scoreboard of expected output vectors popped at each falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;
  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  localparam logic [6:0] O_START = 7'b0000011;
  localparam logic [6:0] O_RUN   = 7'b1111100;
  localparam logic [6:0] O_FRZ   = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b0011101;
  localparam logic [6:0] O_BR    = 7'b1111111;

  typedef struct {
    logic [6:0]  outs;
    logic        err;
    logic [31:0] stall;
    logic [31:0] flush;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_reg_wr, ex_is_load, ex_br_taken, mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, err_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [6:0] outs_obs;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  assign outs_obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  pipe_hazard_ctrl #(.RST_HOLD(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .err_timeout(err_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] outs, input logic err_exp, input string tag);
    exp_t e;
    e.outs  = outs;
    e.err   = err_exp;
    e.stall = m_stall;
    e.flush = m_flush;
    e.tag   = tag;
    sb_q.push_back(e);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (outs != O_START) begin
      if (!outs[6])     m_stall++;
      if (outs == O_BR) m_flush++;
    end
`endif
  endtask

  task automatic compare_out();
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      tests--;
      e = sb_q.pop_front();
      check({e.tag, " outs"},  {25'd0, outs_obs},    {25'd0, e.outs});
      check({e.tag, " err"},   {31'd0, err_timeout}, {31'd0, e.err});
      check({e.tag, " stall"}, stall_cycles,         e.stall);
      check({e.tag, " flush"}, flush_events,         e.flush);
    end
  endtask

  // One clock cycle: expectation queued while inputs are applied, checked at the falling edge.
  task automatic cyc(input logic [6:0] outs, input logic err_exp, input string tag);
    push_exp(outs, err_exp, tag);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_reg_wr = 1'b0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    arst_n = 1'b0;
    #2;
    push_exp(O_START, 1'b0, "in reset");
    compare_out();
    @(posedge clk); #1;
    arst_n = 1'b1;
    cyc(O_START, 1'b0, "hold 1");
    ex_br_taken = 1'b1; mem_req = 1'b1;
    cyc(O_START, 1'b0, "hold 2 ignores inputs");
    idle();
    cyc(O_RUN, 1'b0, "run idle");

    set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    cyc(O_LU, 1'b0, "lu rs2 bubble");
    cyc(O_RUN, 1'b0, "lu single bubble");
    idle();
    set_lu(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    cyc(O_RUN, 1'b0, "lu x0 no stall");
    set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    cyc(O_RUN, 1'b0, "lu rs1 unused");
    set_lu(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
    cyc(O_LU, 1'b0, "lu rs1 bubble");
    idle();
    set_lu(5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
    ex_reg_wr = 1'b0;
    cyc(O_RUN, 1'b0, "lu no reg_wr");

    set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    ex_br_taken = 1'b1;
    cyc(O_BR, 1'b0, "branch over hazard");
    idle();
    cyc(O_RUN, 1'b0, "after branch");

    mem_req = 1'b1; mem_ready = 1'b1;
    cyc(O_RUN, 1'b0, "mem ready same cycle");
    mem_ready = 1'b0;
    cyc(O_FRZ, 1'b0, "mem wait 1");
    cyc(O_FRZ, 1'b0, "mem wait 2");
    cyc(O_FRZ, 1'b0, "mem wait 3");
    mem_ready = 1'b1;
    cyc(O_RUN, 1'b0, "mem release");
    idle();

    mem_req = 1'b1; ex_br_taken = 1'b1;
    cyc(O_FRZ, 1'b0, "branch frozen entry");
    cyc(O_FRZ, 1'b0, "branch frozen wait");
    mem_ready = 1'b1;
    cyc(O_BR, 1'b0, "branch on release");
    idle();
    cyc(O_RUN, 1'b0, "idle after release");

    mem_req = 1'b1;
    cyc(O_FRZ, 1'b0, "wd entry");
    cyc(O_FRZ, 1'b0, "wd wait 1");
    cyc(O_FRZ, 1'b0, "wd wait 2");
    cyc(O_FRZ, 1'b0, "wd wait 3");
    cyc(O_FRZ, 1'b0, "wd wait 4");
    cyc(O_FRZ, 1'b1, "wd err set");
    mem_ready = 1'b1;
    cyc(O_RUN, 1'b1, "wd release sticky");
    idle();
    cyc(O_RUN, 1'b1, "wd idle sticky");

    mem_req = 1'b1;
    cyc(O_FRZ, 1'b1, "pre-reset entry");
    cyc(O_FRZ, 1'b1, "pre-reset wait");
    arst_n = 1'b0;
    #2;
    m_stall = 0;
    m_flush = 0;
    push_exp(O_START, 1'b0, "async reset mid-wait");
    compare_out();
    idle();
    @(posedge clk); #1;
    arst_n = 1'b1;
    cyc(O_START, 1'b0, "re-hold 1");
    cyc(O_START, 1'b0, "re-hold 2");
    cyc(O_RUN, 1'b0, "re-run");

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
